// File: rtl/reg_file_param.sv
// Parametrised register file: two combinational read ports, one write port, and a
// one-entry-per-cycle clear sweep. Optional write-first forwarding under REGFILE_BYPASS_EN.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              wr_err
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr, w_clr_ptr_nxt;
    logic              r_clear_done, w_clear_done_nxt;
    logic              r_wr_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_wr_in_range, w_wr_ok, w_wr_drop;
    logic              w_rd1_ok, w_rd2_ok;
    logic [DATA_W-1:0] w_rd1_mem, w_rd2_mem;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_A;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign w_wr_in_range = in_range(write_addr);
    assign w_wr_ok   = write_en && (r_state == IDLE) && w_wr_in_range && !is_zero_reg(write_addr);
    // Writes to the hardwired zero register are ignored silently, not flagged.
    assign w_wr_drop = write_en && (!w_wr_in_range || (r_state != IDLE));

    assign w_rd1_ok  = in_range(read_addr1) && !is_zero_reg(read_addr1);
    assign w_rd2_ok  = in_range(read_addr2) && !is_zero_reg(read_addr2);
    assign w_rd1_mem = r_mem[read_addr1[IDX_W-1:0]];
    assign w_rd2_mem = r_mem[read_addr2[IDX_W-1:0]];

`ifdef REGFILE_BYPASS_EN
    // w_wr_ok already excludes out-of-range and zero-reg targets, so those still read 0.
    assign read_data1 = !w_rd1_ok ? '0 :
                        (w_wr_ok && (read_addr1 == write_addr)) ? write_data : w_rd1_mem;
    assign read_data2 = !w_rd2_ok ? '0 :
                        (w_wr_ok && (read_addr2 == write_addr)) ? write_data : w_rd2_mem;
`else
    assign read_data1 = w_rd1_ok ? w_rd1_mem : '0;
    assign read_data2 = w_rd2_ok ? w_rd2_mem : '0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_clr_ptr_nxt    = r_clr_ptr;
        w_clear_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_state_nxt   = CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            CLEAR: begin
                if (r_clr_ptr == LAST) begin
                    w_state_nxt      = IDLE;
                    w_clr_ptr_nxt    = '0;
                    w_clear_done_nxt = 1'b1;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_clr_ptr    <= '0;
            r_clear_done <= 1'b0;
            r_wr_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_ptr    <= w_clr_ptr_nxt;
            r_clear_done <= w_clear_done_nxt;
            r_wr_err     <= w_wr_drop;
        end
    end

    // Sweep and write never collide: writes only commit in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (r_state == CLEAR) begin
            r_mem[r_clr_ptr[IDX_W-1:0]] <= '0;
        end else if (w_wr_ok) begin
            r_mem[write_addr[IDX_W-1:0]] <= write_data;
        end
    end

    assign clear_busy = (r_state == CLEAR);
    assign clear_done = r_clear_done;
    assign wr_err     = r_wr_err;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default 32x32 instance plus an 11-deep instance for range checks.
module tb_reg_file_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] rd1, rd2, wd;
    logic        we, creq, busy, done, werr;

    logic [3:0]  b_ra1, b_ra2, b_wa;
    logic [31:0] b_rd1, b_rd2, b_wd;
    logic        b_we, b_creq, b_busy, b_done, b_werr;

    int n_vec = 0;
    int n_err = 0;

    reg_file_param u_dut (
        .clk(clk), .rst_n(rst_n),
        .read_addr1(ra1), .read_addr2(ra2), .read_data1(rd1), .read_data2(rd2),
        .write_en(we), .write_addr(wa), .write_data(wd),
        .clear_req(creq), .clear_busy(busy), .clear_done(done), .wr_err(werr)
    );

    reg_file_param #(.DATA_W(32), .DEPTH(11), .ADDR_W(4), .ZERO_REG(1)) u_d11 (
        .clk(clk), .rst_n(rst_n),
        .read_addr1(b_ra1), .read_addr2(b_ra2), .read_data1(b_rd1), .read_data2(b_rd2),
        .write_en(b_we), .write_addr(b_wa), .write_data(b_wd),
        .clear_req(b_creq), .clear_busy(b_busy), .clear_done(b_done), .wr_err(b_werr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    initial begin
        int nb, nd, done_nb, t;
        rst_n = 1'b0;
        ra1 = '0; ra2 = '0; wa = '0; wd = '0; we = 1'b0; creq = 1'b0;
        b_ra1 = '0; b_ra2 = '0; b_wa = '0; b_wd = '0; b_we = 1'b0; b_creq = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            #1;
            chk($sformatf("rst_rd1[%0d]", a), rd1, 32'd0);
            chk($sformatf("rst_rd2[%0d]", 31 - a), rd2, 32'd0);
        end
        chk("rst_werr", {31'd0, werr}, 32'd0);

        // Basic write/read and same-cycle read behaviour
        @(negedge clk);
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("samecyc_r5", rd1, 32'hDEADBEEF);
`else
        chk("samecyc_r5", rd1, 32'h0);
`endif
        @(negedge clk);
        we = 1'b0; ra1 = 5'd5; ra2 = 5'd0;
        #1;
        chk("rd_r5", rd1, 32'hDEADBEEF);
        chk("rd_r0", rd2, 32'h0);
        we = 1'b1; wa = 5'd0; wd = 32'h1234; ra1 = 5'd0;
        #1;
        chk("r0_bypass_zero", rd1, 32'h0);
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("r0_after_wr", rd1, 32'h0);
        chk("r0_no_werr", {31'd0, werr}, 32'd0);

        // Forwarding vs read-before-write on r7
        we = 1'b1; wa = 5'd7; wd = 32'h11;
        @(negedge clk);
        wa = 5'd7; wd = 32'h55; ra1 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("r7_samecyc", rd1, 32'h55);
`else
        chk("r7_samecyc", rd1, 32'h11);
`endif
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("r7_next", rd1, 32'h55);

        // Fill r1..r31 with their index, then sweep
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i);
            @(negedge clk);
        end
        we = 1'b0; ra1 = 5'd20; ra2 = 5'd31;
        #1;
        chk("fill_r20", rd1, 32'd20);
        chk("fill_r31", rd2, 32'd31);
        creq = 1'b1;
        nb = 0; nd = 0; done_nb = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            creq = 1'b0; we = 1'b0;
            if (done) begin
                nd++;
                done_nb = nb;
            end
            if (busy) begin
                if (nb == 3) begin
                    ra1 = 5'd1; ra2 = 5'd20;
                    #1;
                    chk("swp3_r1", rd1, 32'd0);
                    chk("swp3_r20", rd2, 32'd20);
                end
                if (nb == 5) begin we = 1'b1; wa = 5'd2; wd = 32'hBAD0BAD0; end
                if (nb == 6) chk("busy_werr", {31'd0, werr}, 32'd1);
                if (nb == 7) begin
                    chk("busy_werr_pulse", {31'd0, werr}, 32'd0);
                    ra1 = 5'd2;
                    #1;
                    chk("busy_wr_dropped", rd1, 32'd0);
                end
                if (nb == 8) creq = 1'b1;
                nb++;
            end
        end
        chk("busy_cycles", 32'(nb), 32'd32);
        chk("done_pulses", 32'(nd), 32'd1);
        chk("done_after_last", 32'(done_nb), 32'd32);
        for (int a = 0; a < 32; a += 2) begin
            ra1 = 5'(a); ra2 = 5'(a + 1);
            #1;
            chk($sformatf("post_clr[%0d]", a), rd1, 32'd0);
            chk($sformatf("post_clr[%0d]", a + 1), rd2, 32'd0);
        end

        // Restart in the done cycle with a concurrent write, then reset mid-sweep
        @(negedge clk);
        creq = 1'b1;
        @(negedge clk);
        creq = 1'b0;
        t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        creq = 1'b1; we = 1'b1; wa = 5'd30; wd = 32'h30;
        @(negedge clk);
        creq = 1'b0; we = 1'b0; ra1 = 5'd30;
        #1;
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_wr_r30", rd1, 32'h30);
        repeat (10) @(negedge clk);
        #1;
        chk("swp10_r30", rd1, 32'h30);
        chk("swp10_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_werr", {31'd0, werr}, 32'd0);
        chk("midrst_r30", rd1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("midrst_no_done", 32'(nd), 32'd0);
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        we = 1'b1; wa = 5'd3; wd = 32'hCAFE;
        @(negedge clk);
        we = 1'b0; ra1 = 5'd3;
        #1;
        chk("postrst_r3", rd1, 32'hCAFE);

        // 11-deep instance: out-of-range write and boundary reads
        b_we = 1'b1; b_wa = 4'd12; b_wd = 32'h77;
        @(negedge clk);
        b_we = 1'b0; b_ra1 = 4'd12;
        #1;
        chk("d11_werr", {31'd0, b_werr}, 32'd1);
        chk("d11_rd12", b_rd1, 32'd0);
        @(negedge clk);
        chk("d11_werr_pulse", {31'd0, b_werr}, 32'd0);
        b_we = 1'b1; b_wa = 4'd10; b_wd = 32'hA5;
        @(negedge clk);
        b_we = 1'b0; b_ra1 = 4'd10; b_ra2 = 4'd11;
        #1;
        chk("d11_rd10", b_rd1, 32'hA5);
        chk("d11_rd11", b_rd2, 32'd0);
        chk("d11_no_werr", {31'd0, b_werr}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
